// File: rtl/lcd_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_write_ctrl
// Description : Write-only sequencer for an 8-bit HD44780-style character LCD.
//               Runs the power-on init command sequence, then accepts ASCII
//               characters (valid/ready) and clear requests. Each byte is one
//               bus cycle: SETUP, E_HI and HOLD, each CLK_DIV clocks long.
//               Tracks the cursor over two lines and re-addresses DDRAM at
//               each line end.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_char, i_valid  - character to write and its qualifier
//               i_clear          - clear display / cursor home request
//               o_ready          - high only while idle (request accepted)
//               lcd_e/rs/rw/data - LCD bus (rw is always 0)
//               o_col, o_line    - cursor position of the next character
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_write_ctrl #(
    parameter  int CLK_DIV   = 50,
    parameter  int INIT_WAIT = 1000,
    parameter  int CLR_WAIT  = 2000,
    parameter  int COLS      = 16,
    localparam int COL_W     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_char,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_clear,
    output logic             lcd_e,
    output logic             lcd_rs,
    output logic             lcd_rw,
    output logic [7:0]       lcd_data,
    output logic [COL_W-1:0] o_col,
    output logic             o_line
);

    // One shared counter serves bus phases and both long waits; it is
    // reloaded to zero at the start of every phase or wait.
    localparam int C_MAX_12  = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
    localparam int C_MAX_CNT = (C_MAX_12 > CLK_DIV) ? C_MAX_12 : CLK_DIV;
    localparam int CNT_W     = $clog2(C_MAX_CNT + 1);

    localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] C_PWR_LAST = CNT_W'(INIT_WAIT - 1);
    localparam logic [CNT_W-1:0] C_CLR_LAST = CNT_W'(CLR_WAIT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [COL_W-1:0] C_LAST_COL = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] C_COL_ONE  = COL_W'(1);

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        INIT     = 3'd1,
        IDLE     = 3'd2,
        XFER     = 3'd3,
        ADDR     = 3'd4,
        CLR      = 3'd5
    } state_t;

    // PH_WAIT is the post-clear wait that follows a 0x01 command.
    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_EHI   = 2'd1,
        PH_HOLD  = 2'd2,
        PH_WAIT  = 2'd3
    } phase_t;

    state_t           r_state, w_state;
    phase_t           r_phase, w_phase;
    logic [CNT_W-1:0] r_cnt,   w_cnt;
    logic [1:0]       r_idx,   w_idx;
    logic [7:0]       r_byte,  w_byte;
    logic             r_rs,    w_rs;
    logic [COL_W-1:0] r_col,   w_col;
    logic             r_line,  w_line;
    logic             r_e,     w_e;
    logic             r_ready, w_ready;

    logic w_in_bus;
    logic w_byte_done;

    // Function set 8-bit/2-line, display on, entry increment, clear.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    assign w_in_bus    = ((r_state == INIT) || (r_state == XFER) ||
                          (r_state == ADDR) || (r_state == CLR)) &&
                         (r_phase != PH_WAIT);
    assign w_byte_done = w_in_bus && (r_phase == PH_HOLD) && (r_cnt == C_DIV_LAST);

    always_comb begin
        w_state = r_state;
        w_phase = r_phase;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_byte  = r_byte;
        w_rs    = r_rs;
        w_col   = r_col;
        w_line  = r_line;

        // Phase sequencing common to every bus cycle.
        if (w_in_bus) begin
            if (r_cnt == C_DIV_LAST) begin
                w_cnt = '0;
                case (r_phase)
                    PH_SETUP: w_phase = PH_EHI;
                    PH_EHI:   w_phase = PH_HOLD;
                    default:  w_phase = r_phase;
                endcase
            end else begin
                w_cnt = r_cnt + C_CNT_ONE;
            end
        end

        case (r_state)
            PWR_WAIT: begin
                if (r_cnt == C_PWR_LAST) begin
                    w_cnt   = '0;
                    w_state = INIT;
                    w_phase = PH_SETUP;
                    w_idx   = 2'd0;
                    w_byte  = init_cmd(2'd0);
                    w_rs    = 1'b0;
                end else begin
                    w_cnt = r_cnt + C_CNT_ONE;
                end
            end
            INIT: begin
                if (w_byte_done) begin
                    if (r_idx == 2'd3) begin
                        w_phase = PH_WAIT;
                    end else begin
                        w_idx   = r_idx + 2'd1;
                        w_byte  = init_cmd(r_idx + 2'd1);
                        w_phase = PH_SETUP;
                    end
                end
            end
            CLR: begin
                if (w_byte_done) begin
                    w_phase = PH_WAIT;
                end
            end
            XFER: begin
                if (w_byte_done) begin
                    if (r_col == C_LAST_COL) begin
                        // Line end: move to the other line and re-address DDRAM.
                        w_col   = '0;
                        w_line  = ~r_line;
                        w_state = ADDR;
                        w_byte  = r_line ? 8'h80 : 8'hC0;
                        w_rs    = 1'b0;
                        w_phase = PH_SETUP;
                    end else begin
                        w_col   = r_col + C_COL_ONE;
                        w_state = IDLE;
                    end
                end
            end
            ADDR: begin
                if (w_byte_done) begin
                    w_state = IDLE;
                end
            end
            IDLE: begin
                // Clear wins over a simultaneous character, which stays pending.
                if (i_clear) begin
                    w_state = CLR;
                    w_byte  = 8'h01;
                    w_rs    = 1'b0;
                    w_phase = PH_SETUP;
                    w_cnt   = '0;
                end else if (i_valid) begin
                    w_state = XFER;
                    w_byte  = i_char;
                    w_rs    = 1'b1;
                    w_phase = PH_SETUP;
                    w_cnt   = '0;
                end
            end
            default: begin
                w_state = PWR_WAIT;
                w_phase = PH_SETUP;
                w_cnt   = '0;
            end
        endcase

        // Long wait after a clear command, shared by init and user clear.
        if (((r_state == INIT) || (r_state == CLR)) && (r_phase == PH_WAIT)) begin
            if (r_cnt == C_CLR_LAST) begin
                w_cnt   = '0;
                w_state = IDLE;
                w_col   = '0;
                w_line  = 1'b0;
            end else begin
                w_cnt = r_cnt + C_CNT_ONE;
            end
        end

        // Strobe and ready are registered from the next-state decode so the
        // pins come straight from flops.
        w_e     = (w_phase == PH_EHI) && (w_state != IDLE) && (w_state != PWR_WAIT);
        w_ready = (w_state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PWR_WAIT;
            r_phase <= PH_SETUP;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_byte  <= 8'h00;
            r_rs    <= 1'b0;
            r_col   <= '0;
            r_line  <= 1'b0;
            r_e     <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state;
            r_phase <= w_phase;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_byte  <= w_byte;
            r_rs    <= w_rs;
            r_col   <= w_col;
            r_line  <= w_line;
            r_e     <= w_e;
            r_ready <= w_ready;
        end
    end

    assign lcd_e    = r_e;
    assign lcd_rs   = r_rs;
    assign lcd_rw   = 1'b0;
    assign lcd_data = r_byte;
    assign o_ready  = r_ready;
    assign o_col    = r_col;
    assign o_line   = r_line;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_write_ctrl
// Description : Directed self-checking bench for lcd_write_ctrl with
//               CLK_DIV=2, INIT_WAIT=10, CLR_WAIT=8, COLS=16. A bus monitor
//               records every E strobe (rs, data at rise and fall, width,
//               rise cycle); the main sequence compares against hand-computed
//               values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_write_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_char;
    logic       i_valid;
    logic       o_ready;
    logic       i_clear;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic [3:0] o_col;
    logic       o_line;

    lcd_write_ctrl #(
        .CLK_DIV   (2),
        .INIT_WAIT (10),
        .CLR_WAIT  (8),
        .COLS      (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_char   (i_char),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_clear  (i_clear),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_data (lcd_data),
        .o_col    (o_col),
        .o_line   (o_line)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] d_rise;
        logic [7:0] d_fall;
        int         width;
        int         rise_cyc;
    } strobe_t;

    strobe_t q[$];
    int      cyc   = 0;
    int      tests = 0;
    int      fails = 0;

    // Bus monitor: samples 1 time unit after each rising edge.
    initial begin
        strobe_t cur;
        logic    prev_e;
        prev_e = 1'b0;
        cur    = '{rs: 1'b0, d_rise: 8'h00, d_fall: 8'h00, width: 0, rise_cyc: 0};
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (lcd_e === 1'b1 && prev_e !== 1'b1) begin
                cur.rs       = lcd_rs;
                cur.d_rise   = lcd_data;
                cur.width    = 1;
                cur.rise_cyc = cyc;
            end else if (lcd_e === 1'b1) begin
                cur.width = cur.width + 1;
            end else if (prev_e === 1'b1) begin
                cur.d_fall = lcd_data;
                q.push_back(cur);
            end
            prev_e = lcd_e;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are read 2 time units after the active edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Waits for o_ready (bounded); returns how many sampled cycles it was low.
    task automatic wait_ready(output int low);
        low = 0;
        while (o_ready !== 1'b1 && low < 200) begin
            low++;
            tick();
        end
    endtask

    task automatic send(input logic [7:0] c, input logic clr, output int low);
        i_char  = c;
        i_valid = 1'b1;
        i_clear = clr;
        tick();
        i_valid = 1'b0;
        i_clear = 1'b0;
        wait_ready(low);
    endtask

    // Init sequence check; c0 is the monitor cycle of the last reset edge.
    task automatic check_init(input int c0);
        int          low;
        logic [7:0]  cmds [4];
        cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
        wait_ready(low);
        chk("init_ready_cycle", cyc - c0, 42);
        chk("init_nbytes", q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q.size()) begin
                chk("init_rs",     {31'd0, q[i].rs}, 0);
                chk("init_data",   {24'd0, q[i].d_rise}, {24'd0, cmds[i]});
                chk("init_stable", {24'd0, q[i].d_fall}, {24'd0, cmds[i]});
                chk("init_e_width", q[i].width, 2);
                chk("init_rise_cyc", q[i].rise_cyc - c0, 12 + 6 * i);
            end
        end
        chk("init_col",  {28'd0, o_col}, 0);
        chk("init_line", {31'd0, o_line}, 0);
        q.delete();
    endtask

    initial begin
        int low;
        int c0;

        rst     = 1'b1;
        i_char  = 8'h00;
        i_valid = 1'b0;
        i_clear = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_e",     {31'd0, lcd_e}, 0);
        chk("rst_rs",    {31'd0, lcd_rs}, 0);
        chk("rst_rw",    {31'd0, lcd_rw}, 0);
        chk("rst_data",  {24'd0, lcd_data}, 0);
        chk("rst_ready", {31'd0, o_ready}, 0);
        chk("rst_col",   {28'd0, o_col}, 0);
        chk("rst_line",  {31'd0, o_line}, 0);

        // 1: power-on wait and init commands
        rst = 1'b0;
        c0  = cyc;
        q.delete();
        check_init(c0);

        // 2: single character
        send(8'h35, 1'b0, low);
        chk("s2_low", low, 6);
        chk("s2_nbytes", q.size(), 1);
        if (q.size() > 0) begin
            chk("s2_rs",    {31'd0, q[0].rs}, 1);
            chk("s2_data",  {24'd0, q[0].d_rise}, 32'h35);
            chk("s2_width", q[0].width, 2);
        end
        chk("s2_col",  {28'd0, o_col}, 1);
        chk("s2_line", {31'd0, o_line}, 0);
        q.delete();

        // 5: clear and character together -> only the clear is serviced
        send(8'h39, 1'b1, low);
        chk("s5_low", low, 14);
        chk("s5_nbytes", q.size(), 1);
        if (q.size() > 0) begin
            chk("s5_rs",   {31'd0, q[0].rs}, 0);
            chk("s5_data", {24'd0, q[0].d_rise}, 32'h01);
        end
        chk("s5_col",  {28'd0, o_col}, 0);
        chk("s5_line", {31'd0, o_line}, 0);
        q.delete();

        // 3: sixteen writes from column 0 -> wrap to line 1 with 0xC0
        for (int i = 0; i < 16; i++) begin
            send(8'h31, 1'b0, low);
            chk("s3_low",  low, (i == 15) ? 12 : 6);
            chk("s3_col",  {28'd0, o_col}, (i == 15) ? 0 : i + 1);
            chk("s3_line", {31'd0, o_line}, (i == 15) ? 1 : 0);
        end
        chk("s3_nbytes", q.size(), 17);
        for (int i = 0; i < 16; i++) begin
            if (i < q.size()) begin
                chk("s3_data", {23'd0, q[i].rs, q[i].d_rise}, 32'h131);
            end
        end
        if (q.size() > 16) begin
            chk("s3_addr", {23'd0, q[16].rs, q[16].d_rise}, 32'h0C0);
        end
        q.delete();

        // 4: sixteen more -> wrap back to line 0 with 0x80
        for (int i = 0; i < 16; i++) begin
            send(8'h32, 1'b0, low);
            chk("s4_low",  low, (i == 15) ? 12 : 6);
            chk("s4_col",  {28'd0, o_col}, (i == 15) ? 0 : i + 1);
            chk("s4_line", {31'd0, o_line}, (i == 15) ? 0 : 1);
        end
        chk("s4_nbytes", q.size(), 17);
        if (q.size() > 16) begin
            chk("s4_addr",  {23'd0, q[16].rs, q[16].d_rise}, 32'h080);
            chk("s4_last_data", {23'd0, q[15].rs, q[15].d_rise}, 32'h132);
        end
        q.delete();

        // Later handshake writes 0x39; a clear pulse mid-transfer is ignored.
        i_char  = 8'h39;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_clear = 1'b1;
        low     = 1;
        tick();
        i_clear = 1'b0;
        while (o_ready !== 1'b1 && low < 200) begin
            low++;
            tick();
        end
        chk("late_low", low, 6);
        repeat (5) tick();
        chk("late_ready", {31'd0, o_ready}, 1);
        chk("late_nbytes", q.size(), 1);
        if (q.size() > 0) begin
            chk("late_data", {23'd0, q[0].rs, q[0].d_rise}, 32'h139);
        end
        chk("late_col", {28'd0, o_col}, 1);
        q.delete();

        // 6: reset while E is high during a data write
        i_char  = 8'h37;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        chk("s6_e_high", {31'd0, lcd_e}, 1);
        rst = 1'b1;
        tick();
        chk("s6_e",     {31'd0, lcd_e}, 0);
        chk("s6_rs",    {31'd0, lcd_rs}, 0);
        chk("s6_data",  {24'd0, lcd_data}, 0);
        chk("s6_ready", {31'd0, o_ready}, 0);
        chk("s6_col",   {28'd0, o_col}, 0);
        rst = 1'b0;
        c0  = cyc;
        q.delete();
        check_init(c0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_write_ctrl.md
Name: lcd_write_ctrl

Overview:
Sequencer for the 8-bit HD44780-style character LCD that the keypad decoder feeds with ASCII digit codes. On power-up it runs the LCD init command sequence. It then accepts characters over a valid/ready handshake and generates the E/RS/DATA bus timing. It tracks the cursor over a 2-line display and re-addresses DDRAM automatically at line ends. Clear requests are serviced with the required long wait.

Parameters:
CLK_DIV, 50, clk cycles per bus phase (setup, E-high and hold phases are each CLK_DIV long)
INIT_WAIT, 1000, clk cycles of power-on wait after reset release, before the first command
CLR_WAIT, 2000, extra clk cycles of wait after a 0x01 clear command completes
COLS, 16, characters per line

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock domain, synchronous, active-high
i_char  in  8  ASCII code to write (e.g. 0x30-0x39, 0x20)
i_valid  in  1  i_char is valid
o_ready  out  1  controller can accept a character or clear request this cycle
i_clear  in  1  request display clear and cursor home
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  tied to 0 (write only)
lcd_data  out  8  LCD data bus
o_col  out  clog2(COLS)  column where the next character will be written
o_line  out  1  line where the next character will be written

Behaviour:
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, o_ready=0, o_col=0, o_line=0, state=PWR_WAIT. lcd_rw is 0 at all times.
- States:
  - PWR_WAIT: waits INIT_WAIT cycles.
  - INIT: issues commands 0x38, 0x0C, 0x06, 0x01 in that order, with rs=0. After 0x01 it waits CLR_WAIT cycles.
  - IDLE: o_ready=1.
  - XFER: bus cycle for a command or data byte.
  - ADDR: automatic set-DDRAM-address command.
  - CLR: 0x01 command plus CLR_WAIT wait.
- Bus cycle, each byte exactly 3*CLK_DIV cycles:
  - SETUP phase: rs and data driven, e=0.
  - E_HI phase: e=1.
  - HOLD phase: e=0.
  - rs and data stay stable across all three phases.
- o_ready is high only in IDLE. It drops on the cycle after an accepted transfer.
- Accept rule in IDLE:
  - i_clear=1: clear is accepted and i_valid is ignored that cycle (clear has priority; the character is not consumed).
  - Otherwise, i_valid=1: i_char is latched and written with rs=1.
  - i_clear is sampled only in IDLE. Outside IDLE it is ignored, not queued.
- Cursor after each data write:
  - If o_col < COLS-1: o_col increments.
  - If o_col = COLS-1: o_col becomes 0, o_line toggles, and the controller issues address command 0xC0 (new line 1) or 0x80 (new line 0) as a full bus cycle before returning to IDLE.
- Clear: issues 0x01, waits CLR_WAIT, then sets o_col=0 and o_line=0 and returns to IDLE.
- Counters: phase and wait counters are sized for max(INIT_WAIT, CLR_WAIT, CLK_DIV). Counter wrap is not used; counters reload per phase.
- Reset mid-operation (any state, including E_HI): on the next clk all outputs take their reset values, any in-flight byte is abandoned, and the full init sequence restarts from PWR_WAIT.

Test Plan:
Use CLK_DIV=2, INIT_WAIT=10, CLR_WAIT=8, COLS=16.
1. Release rst -> lcd_e stays 0 for 10 cycles. Then 0x38, 0x0C, 0x06, 0x01 appear with rs=0, each with lcd_e high exactly 2 cycles and 6 cycles per byte. o_ready rises at cycle 10+24+8=42.
2. In IDLE, i_char=0x35 with i_valid=1 for one cycle -> one bus cycle with rs=1, data=0x35. o_ready is low 6 cycles, then o_col=1, o_line=0.
3. 16 consecutive writes of 0x31 -> after the 16th data byte, command 0xC0 with rs=0. o_ready is low 12 cycles for that write. Final state o_col=0, o_line=1.
4. 16 further writes -> final address command is 0x80, with o_line=0 and o_col=0.
5. In IDLE, i_clear=1 and i_valid=1 (0x39) in the same cycle -> only 0x01 is sent and o_ready is low 6+8=14 cycles. 0x39 is not written until a later handshake. o_col=0, o_line=0.
6. Assert rst for 1 cycle while lcd_e=1 during a data write -> the next cycle shows lcd_e=0, lcd_data=0x00, o_ready=0. The init sequence from scenario 1 then repeats.
